// File: rtl/aos_param_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aos_param_fifo_pkg
// Description : Shared constants for the parametrised shell-glue FIFO.
//               FIFO_TYPE_* select the read mode of aos_param_fifo.
//               Existing per-path *_FIFO_Type / *_FIFO_Depth constants are
//               passed straight through as TYPE / LOG_DEPTH.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package aos_param_fifo_pkg;

    localparam int unsigned FIFO_TYPE_REG  = 0;  // registered read, 1-cycle latency
    localparam int unsigned FIFO_TYPE_FWFT = 1;  // first-word-fall-through

    // Pointer width; a 1-entry FIFO still needs a 1-bit (constant zero) pointer.
    function automatic int unsigned ptr_width(input int unsigned log_depth);
        return (log_depth == 0) ? 1 : log_depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aos_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : aos_fifo_mem
// Description : Storage array for aos_param_fifo. One write port; the read
//               port is registered (TYPE 0) or asynchronous (TYPE 1).
// Ports       : clk, rst         - clock, synchronous active-high reset
//               wr_en_i/addr/data - write port
//               rd_en_i, rd_addr_i - read request (used in registered mode)
//               rd_data_o         - read data
// Revision    : 1.0 - initial release
// ============================================================================
module aos_fifo_mem
    import aos_param_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned LOG_DEPTH = 2,
    parameter int unsigned TYPE      = FIFO_TYPE_REG
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en_i,
    input  logic [ptr_width(LOG_DEPTH)-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0]                   wr_data_i,
    input  logic                               rd_en_i,
    input  logic [ptr_width(LOG_DEPTH)-1:0]    rd_addr_i,
    output logic [WIDTH-1:0]                   rd_data_o
);

    localparam int unsigned AW      = ptr_width(LOG_DEPTH);
    // Sized to the full address space so indexing is width-exact; with
    // LOG_DEPTH = 0 the second entry is simply never addressed.
    localparam int unsigned ENTRIES = 1 << AW;

    logic [WIDTH-1:0] mem_q [ENTRIES];

    // Contents are not reset: the control logic never reads an unwritten slot.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    generate
        if (TYPE == FIFO_TYPE_REG) begin : g_reg_read
            logic [WIDTH-1:0] rd_data_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= '0;
                end else if (rd_en_i) begin
                    rd_data_q <= mem_q[rd_addr_i];
                end
            end
            assign rd_data_o = rd_data_q;
        end else begin : g_fwft_read
            assign rd_data_o = mem_q[rd_addr_i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aos_param_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aos_param_fifo
// Description : Parametrised single-clock FIFO with occupancy count,
//               almost-full flag and sticky, clearable overflow/underflow.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               enq_en, enq_data         - push request / data
//               full, almost_full        - space flags
//               deq_en                   - pop request
//               deq_data, deq_valid      - output word and its qualifier
//               empty, count             - occupancy
//               overflow, underflow      - sticky error flags
//               clear_err                - clears both error flags
// Revision    : 1.0 - initial release
// ============================================================================
module aos_param_fifo
    import aos_param_fifo_pkg::*;
#(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned LOG_DEPTH   = 2,
    parameter int unsigned TYPE        = FIFO_TYPE_REG,
    parameter int unsigned AFULL_SLACK = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enq_en,
    input  logic [WIDTH-1:0]     enq_data,
    output logic                 full,
    output logic                 almost_full,
    input  logic                 deq_en,
    output logic [WIDTH-1:0]     deq_data,
    output logic                 deq_valid,
    output logic                 empty,
    output logic [LOG_DEPTH:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clear_err
);

    localparam int unsigned DEPTH       = 1 << LOG_DEPTH;
    localparam int unsigned PW          = ptr_width(LOG_DEPTH);
    localparam int unsigned CW          = LOG_DEPTH + 1;
    localparam int unsigned AFULL_LEVEL = DEPTH - AFULL_SLACK;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overflow_q,  overflow_d;
    logic          underflow_q, underflow_d;
    logic          w_push;
    logic          w_pop;

    // Flags decode only the registered count, so a same-cycle pop never
    // frees space for a push and a same-cycle push never feeds a pop.
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(AFULL_LEVEL));
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    assign w_push = enq_en && !full;
    assign w_pop  = deq_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        // Explicit wrap keeps a 1-entry FIFO's pointer pinned at zero.
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new error event takes priority over a same-cycle clear.
        if (enq_en && full) begin
            overflow_d = 1'b1;
        end else if (clear_err) begin
            overflow_d = 1'b0;
        end
        if (deq_en && empty) begin
            underflow_d = 1'b1;
        end else if (clear_err) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    aos_fifo_mem #(
        .WIDTH     (WIDTH),
        .LOG_DEPTH (LOG_DEPTH),
        .TYPE      (TYPE)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (enq_data),
        .rd_en_i   (w_pop),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (deq_data)
    );

    generate
        if (TYPE == FIFO_TYPE_REG) begin : g_reg_valid
            // Valid for exactly the cycle after an accepted pop.
            logic deq_valid_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    deq_valid_q <= 1'b0;
                end else begin
                    deq_valid_q <= w_pop;
                end
            end
            assign deq_valid = deq_valid_q;
        end else begin : g_fwft_valid
            assign deq_valid = !empty;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_aos_param_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_aos_param_fifo
// Description : Self-checking bench for aos_param_fifo. Three instances share
//               one stimulus stream:
//                 A: WIDTH 32, LOG_DEPTH 2, FWFT,       AFULL_SLACK 1
//                 B: WIDTH 32, LOG_DEPTH 2, registered, AFULL_SLACK 2
//                 C: WIDTH 8,  LOG_DEPTH 0, registered, AFULL_SLACK 1
//               A list-based reference model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aos_param_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_en;
    logic [31:0] enq_data;
    logic        deq_en;
    logic        clear_err;

    logic        a_full, a_afull, a_dv, a_empty, a_ovf, a_unf;
    logic [31:0] a_dd;
    logic [2:0]  a_cnt;
    logic        b_full, b_afull, b_dv, b_empty, b_ovf, b_unf;
    logic [31:0] b_dd;
    logic [2:0]  b_cnt;
    logic        c_full, c_afull, c_dv, c_empty, c_ovf, c_unf;
    logic [7:0]  c_dd;
    logic [0:0]  c_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    aos_param_fifo #(.WIDTH(32), .LOG_DEPTH(2), .TYPE(1), .AFULL_SLACK(1)) u_a (
        .clk(clk), .rst(rst), .enq_en(enq_en), .enq_data(enq_data),
        .full(a_full), .almost_full(a_afull), .deq_en(deq_en), .deq_data(a_dd),
        .deq_valid(a_dv), .empty(a_empty), .count(a_cnt), .overflow(a_ovf),
        .underflow(a_unf), .clear_err(clear_err));

    aos_param_fifo #(.WIDTH(32), .LOG_DEPTH(2), .TYPE(0), .AFULL_SLACK(2)) u_b (
        .clk(clk), .rst(rst), .enq_en(enq_en), .enq_data(enq_data),
        .full(b_full), .almost_full(b_afull), .deq_en(deq_en), .deq_data(b_dd),
        .deq_valid(b_dv), .empty(b_empty), .count(b_cnt), .overflow(b_ovf),
        .underflow(b_unf), .clear_err(clear_err));

    aos_param_fifo #(.WIDTH(8), .LOG_DEPTH(0), .TYPE(0), .AFULL_SLACK(1)) u_c (
        .clk(clk), .rst(rst), .enq_en(enq_en), .enq_data(enq_data[7:0]),
        .full(c_full), .almost_full(c_afull), .deq_en(deq_en), .deq_data(c_dd),
        .deq_valid(c_dv), .empty(c_empty), .count(c_cnt), .overflow(c_ovf),
        .underflow(c_unf), .clear_err(clear_err));

    // ---------------- configuration of the three instances ----------------
    function automatic int dep(input int k);
        return (k == 2) ? 1 : 4;
    endfunction
    function automatic int slack(input int k);
        return (k == 1) ? 2 : 1;
    endfunction
    function automatic bit is_fwft(input int k);
        return (k == 0);
    endfunction
    function automatic logic [31:0] dmask(input int k);
        return (k == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    // ---------------- reference model: ordered list per instance -----------
    logic [31:0] ml  [3][4];   // ml[k][0] is the oldest entry
    int          mc  [3];
    bit          mo  [3];
    bit          mu  [3];
    bit          mdv [3];
    logic [31:0] mdd [3];
    bit          started = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mc[k]  = 0;
                mo[k]  = 1'b0;
                mu[k]  = 1'b0;
                mdv[k] = 1'b0;
                mdd[k] = '0;
            end else begin
                bit          f;
                bit          e;
                bit          pu;
                bit          po;
                logic [31:0] head;
                f    = (mc[k] == dep(k));
                e    = (mc[k] == 0);
                pu   = enq_en && !f;
                po   = deq_en && !e;
                head = ml[k][0];
                if (enq_en && f)   mo[k] = 1'b1;
                else if (clear_err) mo[k] = 1'b0;
                if (deq_en && e)   mu[k] = 1'b1;
                else if (clear_err) mu[k] = 1'b0;
                if (po) begin
                    for (int j = 0; j < 3; j++) ml[k][j] = ml[k][j + 1];
                    mc[k] = mc[k] - 1;
                end
                if (pu) begin
                    ml[k][mc[k]] = enq_data & dmask(k);
                    mc[k] = mc[k] + 1;
                end
                mdv[k] = po;
                if (po) mdd[k] = head;
            end
        end
        if (rst) started = 1'b1;
    end

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d at %0t: got %0h, expected %0h", name, k, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare against the model ------------------
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                logic [31:0] ad, ac;
                logic        af, aaf, ae, av, ao, au;
                case (k)
                    0: begin ad = a_dd; ac = 32'(a_cnt); af = a_full; aaf = a_afull;
                             ae = a_empty; av = a_dv; ao = a_ovf; au = a_unf; end
                    1: begin ad = b_dd; ac = 32'(b_cnt); af = b_full; aaf = b_afull;
                             ae = b_empty; av = b_dv; ao = b_ovf; au = b_unf; end
                    default: begin ad = 32'(c_dd); ac = 32'(c_cnt); af = c_full; aaf = c_afull;
                             ae = c_empty; av = c_dv; ao = c_ovf; au = c_unf; end
                endcase
                chk("count",       k, ac,          32'(mc[k]));
                chk("full",        k, 32'(af),     32'(mc[k] == dep(k)));
                chk("empty",       k, 32'(ae),     32'(mc[k] == 0));
                chk("almost_full", k, 32'(aaf),    32'(mc[k] >= dep(k) - slack(k)));
                chk("overflow",    k, 32'(ao),     32'(mo[k]));
                chk("underflow",   k, 32'(au),     32'(mu[k]));
                if (is_fwft(k)) begin
                    chk("deq_valid", k, 32'(av), 32'(mc[k] != 0));
                    if (mc[k] != 0) chk("deq_data", k, ad, ml[k][0]);
                end else begin
                    chk("deq_valid", k, 32'(av), 32'(mdv[k]));
                    chk("deq_data",  k, ad,      mdd[k]);
                end
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic drive(input bit e, input logic [31:0] d, input bit p,
                         input bit c, input bit r);
        enq_en    = e;
        enq_data  = d;
        deq_en    = p;
        clear_err = c;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; enq_en = 1'b0; enq_data = '0; deq_en = 1'b0; clear_err = 1'b0;

        // Reset state (push/pop during reset must be ignored)
        drive(1, 32'hDEAD, 1, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("lit_rst_empty",  0, 32'(a_empty), 1);
        chk("lit_rst_count",  0, 32'(a_cnt),   0);
        chk("lit_rst_dv",     1, 32'(b_dv),    0);
        chk("lit_rst_dd",     1, b_dd,         0);
        chk("lit_rst_afull",  1, 32'(b_afull), 0);

        // Fill A0..A3, fifth push overflows
        for (int i = 0; i < 4; i++) drive(1, 32'hA0 + i, 0, 0, 0);
        chk("lit_fill_full",  0, 32'(a_full), 1);
        chk("lit_fill_count", 0, 32'(a_cnt),  4);
        chk("lit_d0_full",    2, 32'(c_full), 1);
        chk("lit_d0_empty",   2, 32'(c_empty), 0);
        drive(1, 32'hA4, 0, 0, 0);
        chk("lit_ovf",        0, 32'(a_ovf), 1);
        chk("lit_ovf_count",  0, 32'(a_cnt), 4);

        // Drain in order: FWFT head before pop, registered data after pop
        for (int i = 0; i < 4; i++) begin
            chk("lit_fwft_head", 0, a_dd, 32'hA0 + i);
            drive(0, 0, 1, 0, 0);
            chk("lit_reg_dv",    1, 32'(b_dv), 1);
            chk("lit_reg_dd",    1, b_dd, 32'hA0 + i);
        end
        chk("lit_drained", 0, 32'(a_empty), 1);

        // Sticky error flags and set-wins-over-clear
        drive(0, 0, 0, 1, 0);
        chk("lit_clr_ovf", 0, 32'(a_ovf), 0);
        drive(0, 0, 1, 0, 0);
        chk("lit_unf",     0, 32'(a_unf), 1);
        drive(0, 0, 0, 1, 0);
        chk("lit_clr_unf", 0, 32'(a_unf), 0);
        drive(0, 0, 1, 1, 0);
        chk("lit_unf_wins", 0, 32'(a_unf), 1);
        drive(0, 0, 0, 1, 0);

        // Registered-read latency
        drive(1, 32'h11, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk("lit_lat_dv", 1, 32'(b_dv), 1);
        chk("lit_lat_dd", 1, b_dd, 32'h11);
        drive(0, 0, 0, 0, 0);
        chk("lit_lat_dv_clr",  1, 32'(b_dv), 0);
        chk("lit_lat_dd_hold", 1, b_dd, 32'h11);

        // Streaming at count 2: pointers wrap several times
        drive(1, 32'hE0, 0, 0, 0);
        drive(1, 32'hE1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'(i), 1, 0, 0);
            chk("lit_stream_cnt",   0, 32'(a_cnt),   2);
            chk("lit_stream_afull", 1, 32'(b_afull), 1);
        end
        chk("lit_stream_head", 0, a_dd, 32'h8);

        // Almost-full threshold with slack 2, and push-while-full with pop
        drive(0, 0, 0, 0, 1);
        drive(1, 32'h51, 0, 0, 0);
        chk("lit_af_c1", 1, 32'(b_afull), 0);
        drive(1, 32'h52, 0, 0, 0);
        chk("lit_af_c2", 1, 32'(b_afull), 1);
        drive(1, 32'h53, 0, 0, 0);
        drive(1, 32'h54, 0, 0, 0);
        chk("lit_af_full", 1, 32'(b_full), 1);
        drive(1, 32'h55, 1, 0, 0);
        chk("lit_af_cnt3", 1, 32'(b_cnt), 3);
        chk("lit_af_ovf",  1, 32'(b_ovf), 1);

        // Single-entry FIFO and reset mid-stream
        drive(0, 0, 0, 0, 1);
        drive(1, 32'h77, 0, 0, 0);
        chk("lit_d1_full",  2, 32'(c_full),  1);
        chk("lit_d1_empty", 2, 32'(c_empty), 0);
        drive(1, 32'h78, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        chk("lit_mid_cnt",  2, 32'(c_cnt),   0);
        chk("lit_mid_emp",  2, 32'(c_empty), 1);
        chk("lit_mid_ovf",  2, 32'(c_ovf),   0);
        chk("lit_mid_dv",   2, 32'(c_dv),    0);
        chk("lit_mid_dd",   2, 32'(c_dd),    0);
        drive(0, 0, 1, 0, 0);
        chk("lit_mid_unf",  2, 32'(c_unf),   1);

        // Randomised traffic, push-heavy then pop-heavy
        for (int i = 0; i < 3000; i++) begin
            int pe;
            pe = (i < 1500) ? 70 : 40;
            drive($urandom_range(0, 99) < pe,
                  $urandom,
                  $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 199) == 0);
        end

        drive(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
